risci_dmem: RTL and testbench

Byte-addressed, little-endian data memory that responds to the core's data port (`daddr`/`din`/`dout`/`dlen`/`we`/`re`). Serves sized loads and stores of 1, 2, 4 and 8 bytes from an internal array of 64-bit words. Accesses that straddle an 8-byte word boundary are split into two internal beats by a small state machine, with `busy` telling the core to hold its request. Sits between the core's data port and the rest of the memory system as the default RAM slave.

---
 rtl/risci_dmem_if.sv | 22 ++
 rtl/risci_dmem.sv | 162 ++++++++++++++++
 tb/tb_risci_dmem.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/risci_dmem_if.sv
// Core data-port bundle for risci_dmem: request from the core, response back.
interface risci_dmem_if;
  logic [63:0] daddr;
  logic [63:0] dout;
  logic [1:0]  dlen;
  logic        re;
  logic        we;
  logic [63:0] din;
  logic        dvalid;
  logic        derr;
  logic        busy;

  modport master (
    output daddr, dout, dlen, re, we,
    input  din, dvalid, derr, busy
  );

  modport slave (
    input  daddr, dout, dlen, re, we,
    output din, dvalid, derr, busy
  );
endinterface

// File: rtl/risci_dmem.sv
// Byte-addressed little-endian data RAM; sized 1/2/4/8-byte loads and stores,
// word-straddling accesses are split into two beats while busy holds the core.
module risci_dmem #(
  parameter int          DEPTH = 512,
  parameter logic [63:0] BASE  = 64'h0
) (
  input logic         clk,
  input logic         rst,
  risci_dmem_if.slave bus
);
  localparam int          AW  = $clog2(DEPTH);
  localparam logic [64:0] CAP = 65'(DEPTH) << 3;

  typedef enum logic {IDLE, SPLIT} state_t;
  state_t state_reg, state_next;

  logic [63:0] mem [DEPTH];
  logic [63:0] rdata_reg;

  logic [64:0]   off;
  logic [64:0]   end_addr;
  logic [3:0]    nbytes;
  logic [7:0]    nmask;
  logic [15:0]   be16;
  logic [127:0]  wdata128;
  logic [AW-1:0] widx;
  logic          oor, err, accept, split_req;

  logic [AW-1:0] widx_reg;
  logic [7:0]    be_hi_reg;
  logic [63:0]   wdata_hi_reg;
  logic          wr_reg;
  logic [63:0]   beat1_reg;
  logic [2:0]    lane_reg;
  logic [1:0]    len_reg;
  logic          dvalid_reg, derr_reg, rd_resp_reg, split_resp_reg;
  logic [63:0]   din_hold_reg;

  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_be;
  logic [63:0]   mem_wdata;
  logic [63:0]   lo_word, assembled, len_mask, din_comb;
  logic [5:0]    sh;
  logic [3:0]    resp_n;

  // Request decode; range arithmetic in 65 bits so a wrap past 2^64 is caught.
  always_comb begin
    nbytes = 4'd1 << bus.dlen;
    case (bus.dlen)
      2'd0:    nmask = 8'h01;
      2'd1:    nmask = 8'h03;
      2'd2:    nmask = 8'h0F;
      default: nmask = 8'hFF;
    endcase
    off       = {1'b0, bus.daddr} - {1'b0, BASE};
    end_addr  = off + 65'(nbytes);
    oor       = (bus.daddr < BASE) || (end_addr > CAP);
    err       = oor || (bus.re && bus.we);
    accept    = rst && (state_reg == IDLE) && (bus.re || bus.we);
    be16      = {8'h00, nmask} << off[2:0];
    wdata128  = {64'h0, bus.dout} << {off[2:0], 3'b000};
    split_req = !err && (be16[15:8] != 8'h00);
    widx      = off[AW+2:3];
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:  if (accept && split_req) state_next = SPLIT;
      SPLIT: state_next = IDLE;
    endcase
  end

  // Single RAM port: beat 2 of a split owns it, otherwise the incoming request.
  always_comb begin
    mem_addr  = widx;
    mem_be    = 8'h00;
    mem_wdata = wdata128[63:0];
    if (state_reg == SPLIT) begin
      mem_addr  = widx_reg + AW'(1);
      mem_wdata = wdata_hi_reg;
      if (wr_reg) mem_be = be_hi_reg;
    end else if (accept && bus.we && !err) begin
      mem_be = be16[7:0];
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 8; i++) begin
      if (mem_be[i]) mem[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
    end
    rdata_reg <= mem[mem_addr];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= IDLE;
      dvalid_reg     <= 1'b0;
      derr_reg       <= 1'b0;
      rd_resp_reg    <= 1'b0;
      split_resp_reg <= 1'b0;
      din_hold_reg   <= 64'h0;
      lane_reg       <= 3'd0;
      len_reg        <= 2'd0;
      widx_reg       <= '0;
      be_hi_reg      <= 8'h00;
      wdata_hi_reg   <= 64'h0;
      wr_reg         <= 1'b0;
      beat1_reg      <= 64'h0;
    end else begin
      state_reg    <= state_next;
      din_hold_reg <= din_comb;
      dvalid_reg   <= 1'b0;
      derr_reg     <= 1'b0;
      if (state_reg == SPLIT) begin
        dvalid_reg     <= 1'b1;
        rd_resp_reg    <= !wr_reg;
        split_resp_reg <= 1'b1;
        beat1_reg      <= rdata_reg;
      end else if (accept) begin
        lane_reg       <= off[2:0];
        len_reg        <= bus.dlen;
        widx_reg       <= widx;
        be_hi_reg      <= be16[15:8];
        wdata_hi_reg   <= wdata128[127:64];
        wr_reg         <= bus.we;
        split_resp_reg <= 1'b0;
        if (!split_req) begin
          dvalid_reg  <= 1'b1;
          derr_reg    <= err;
          rd_resp_reg <= bus.re && !err;
        end
      end
    end
  end

  assign resp_n = 4'd1 << len_reg;

  for (genvar gi = 0; gi < 8; gi++) begin : g_len_mask
    assign len_mask[8*gi +: 8] = {8{4'(gi) < resp_n}};
  end

  // Read data is steered from the RAM output register in the response cycle;
  // between responses din replays the held value.
  always_comb begin
    sh        = {lane_reg, 3'b000};
    lo_word   = split_resp_reg ? beat1_reg : rdata_reg;
    assembled = lo_word >> sh;
    if (split_resp_reg) assembled = assembled | (rdata_reg << (7'd64 - {1'b0, sh}));
    assembled = assembled & len_mask;
    din_comb  = din_hold_reg;
    if (dvalid_reg) begin
      if (derr_reg)         din_comb = 64'h0;
      else if (rd_resp_reg) din_comb = assembled;
    end
  end

  assign bus.din    = din_comb;
  assign bus.dvalid = dvalid_reg;
  assign bus.derr   = derr_reg;
  assign bus.busy   = (state_reg == SPLIT);
endmodule

// File: tb/tb_risci_dmem.sv
// Directed bench for risci_dmem: byte-level memory model plus per-cycle output compare.
module tb_risci_dmem;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  risci_dmem_if bus ();
  risci_dmem #(.DEPTH(512), .BASE(64'h0)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    int          cyc;
    bit          err;
    bit          rd;
    logic [63:0] data;
  } exp_t;

  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  int          split_cyc = -10;
  bit          chk_en = 1'b0;
  logic [63:0] last_din = 64'h0;
  logic [7:0]  mdl [0:4095];
  exp_t        q [$];

  bit          exp_v, e_err;
  logic [63:0] ed;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      if (!rst) begin
        chk("rst_dvalid", 64'(bus.dvalid), 64'h0);
        chk("rst_derr",   64'(bus.derr),   64'h0);
        chk("rst_busy",   64'(bus.busy),   64'h0);
        chk("rst_din",    bus.din,         64'h0);
        q.delete();
        last_din = 64'h0;
      end else begin
        exp_v = (q.size() > 0) && (q[0].cyc == cyc);
        e_err = 1'b0;
        ed    = last_din;
        if (exp_v) begin
          e_err = q[0].err;
          if (q[0].err || q[0].rd) ed = q[0].data;
        end
        chk("dvalid", 64'(bus.dvalid), 64'(exp_v));
        chk("derr",   64'(bus.derr),   64'(e_err));
        chk("din",    bus.din,         ed);
        chk("busy",   64'(bus.busy),   64'(cyc == split_cyc));
        last_din = ed;
        if (exp_v) void'(q.pop_front());
      end
    end
  end

  task automatic req(input bit r, input bit w, input logic [63:0] a, input logic [1:0] l,
                     input logic [63:0] d, input bit meddle, output logic [63:0] rv);
    int          n;
    int          bi;
    bit          e;
    bit          sp;
    logic [64:0] endx;
    logic [63:0] v;
    exp_t        x;
    bus.re = r; bus.we = w; bus.daddr = a; bus.dlen = l; bus.dout = d;
    @(posedge clk); #1;
    n    = 1 << l;
    endx = {1'b0, a} + 65'(n);
    e    = (r && w) || (endx > 65'd4096);
    v    = 64'h0;
    sp   = 1'b0;
    if (!e) begin
      bi = int'(a[11:0]);
      sp = (int'(a[2:0]) + n) > 8;
      for (int i = 0; i < n; i++) begin
        if (r) v = v | (64'(mdl[bi+i]) << (8*i));
        if (w) mdl[bi+i] = d[8*i +: 8];
      end
    end
    x.cyc  = sp ? cyc + 1 : cyc;
    x.err  = e;
    x.rd   = r && !e;
    x.data = (r && !e) ? v : 64'h0;
    q.push_back(x);
    rv = x.data;
    if (sp) begin
      split_cyc = cyc;
      if (meddle) begin
        bus.re = 1'b0; bus.we = 1'b1; bus.daddr = 64'h0; bus.dlen = 2'd3;
        bus.dout = 64'hDEADBEEFCAFEF00D;
      end
      @(posedge clk); #1;
    end
    bus.re = 1'b0; bus.we = 1'b0;
  endtask

  initial begin
    logic [63:0] rv;
    logic [63:0] pat;
    rst = 1'b1;
    bus.re = 1'b0; bus.we = 1'b0; bus.daddr = 64'h0; bus.dlen = 2'd0; bus.dout = 64'h0;
    #3 rst = 1'b0;
    chk_en = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    // Known pattern in bytes 0x00..0x3F: byte a holds (a*7+3) mod 256.
    for (int wi = 0; wi < 8; wi++) begin
      pat = 64'h0;
      for (int b = 0; b < 8; b++) pat[8*b +: 8] = 8'((wi*8 + b)*7 + 3);
      req(1'b0, 1'b1, 64'(wi*8), 2'd3, pat, 1'b0, rv);
    end

    req(1'b0, 1'b1, 64'h10, 2'd3, 64'h1122334455667788, 1'b0, rv);
    req(1'b1, 1'b0, 64'h13, 2'd0, 64'h0, 1'b0, rv);
    chk("pin_rd13_b", rv, 64'h55);

    req(1'b0, 1'b1, 64'h17, 2'd1, 64'hBEEF, 1'b0, rv);
    req(1'b1, 1'b0, 64'h10, 2'd3, 64'h0, 1'b0, rv);
    chk("pin_rd10_d", rv, 64'hEF22334455667788);
    req(1'b1, 1'b0, 64'h17, 2'd1, 64'h0, 1'b0, rv);
    chk("pin_rd17_h", rv, 64'hBEEF);

    req(1'b1, 1'b0, 64'hFFE, 2'd2, 64'h0, 1'b0, rv);
    req(1'b1, 1'b0, 64'hFFFFFFFFFFFFFFFC, 2'd3, 64'h0, 1'b0, rv);
    req(1'b0, 1'b1, 64'h1000, 2'd3, 64'h0123456789ABCDEF, 1'b0, rv);
    req(1'b1, 1'b0, 64'h0, 2'd3, 64'h0, 1'b0, rv);
    chk("pin_word0", rv, 64'h342D261F18110A03);
    req(1'b0, 1'b1, 64'hFF8, 2'd3, 64'h8877665544332211, 1'b0, rv);
    req(1'b1, 1'b0, 64'hFFC, 2'd2, 64'h0, 1'b0, rv);
    chk("pin_rdFFC", rv, 64'h88776655);
    req(1'b0, 1'b1, 64'hFFF, 2'd0, 64'h99, 1'b0, rv);
    req(1'b1, 1'b0, 64'hFF8, 2'd3, 64'h0, 1'b0, rv);
    chk("pin_rdFF8", rv, 64'h9977665544332211);
    req(1'b1, 1'b0, 64'hFFC, 2'd3, 64'h0, 1'b0, rv);

    req(1'b1, 1'b1, 64'h20, 2'd3, 64'h5555555555555555, 1'b0, rv);
    req(1'b1, 1'b0, 64'h20, 2'd3, 64'h0, 1'b0, rv);
    chk("pin_rd20", rv, 64'h140D06FFF8F1EAE3);

    // Abort a split write between its two beats.
    bus.we = 1'b1; bus.daddr = 64'h1E; bus.dlen = 2'd2; bus.dout = 64'hAABBCCDD;
    @(posedge clk); #1;
    mdl[12'h1E] = 8'hDD;
    mdl[12'h1F] = 8'hCC;
    bus.we = 1'b0;
    rst = 1'b0;
    #1;
    chk("abort_busy",   64'(bus.busy),   64'h0);
    chk("abort_dvalid", 64'(bus.dvalid), 64'h0);
    chk("abort_din",    bus.din,         64'h0);
    @(posedge clk); #1;
    rst = 1'b1;
    req(1'b1, 1'b0, 64'h1E, 2'd1, 64'h0, 1'b0, rv);
    chk("pin_rd1E", rv, 64'hCCDD);
    req(1'b1, 1'b0, 64'h20, 2'd1, 64'h0, 1'b0, rv);
    chk("pin_rd20_h", rv, 64'hEAE3);

    req(1'b1, 1'b0, 64'h0,  2'd3, 64'h0, 1'b0, rv);
    req(1'b1, 1'b0, 64'h8,  2'd3, 64'h0, 1'b0, rv);
    req(1'b1, 1'b0, 64'h10, 2'd3, 64'h0, 1'b0, rv);
    chk("pin_b2b_10", rv, 64'hEF22334455667788);

    req(1'b1, 1'b0, 64'h0C, 2'd3, 64'h0, 1'b1, rv);
    chk("pin_rd0C", rv, 64'h556677886C655E57);
    req(1'b1, 1'b0, 64'h0, 2'd3, 64'h0, 1'b0, rv);
    chk("pin_word0_hold", rv, 64'h342D261F18110A03);
    req(1'b1, 1'b0, 64'h1E, 2'd2, 64'h0, 1'b0, rv);
    chk("pin_rd1E_w", rv, 64'hEAE3CCDD);

    repeat (3) @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
